// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexed scan scheduler for a 3-digit, common-anode 7-segment
// display. It accepts a 3-digit BCD word through a valid/ready handshake
// into a pending buffer. At each frame boundary the buffer moves into the
// display register. The block then steps a 2-bit digit index through
// ones, tens, hundreds and one all-off dead-time slot.
//
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both high. load_ready is high exactly when the pending
// buffer is empty. load_valid is ignored while load_ready is low.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   bcd_in       {hundreds, tens, ones} BCD word
//   load_valid   bcd_in is valid this cycle
//   load_ready   pending buffer is empty
//   lzs_en       leading-zero suppression enable
//   blank_en     force the display dark (timing keeps running)
//   dig_sel      digit index to the decoder (3 = all anodes off)
//   seg_out      {g,f,e,d,c,b,a}, active-low
//   frame_start  one-cycle pulse, aligned with the first D0 output cycle
// -----------------------------------------------------------------------------
module seg_scan_controller #(
   parameter int CLK_DIV   = 50000,
   parameter int DEC_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [11:0]          bcd_in,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic                 lzs_en,
   input  logic                 blank_en,
   output logic [DEC_WIDTH-1:0] dig_sel,
   output logic [6:0]           seg_out,
   output logic                 frame_start
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Each state's encoding equals the digit index it drives.
   typedef enum logic [1:0] {
      S_D0  = 2'd0,
      S_D1  = 2'd1,
      S_D2  = 2'd2,
      S_GAP = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [11:0]   pend;
   logic          pend_full;
   logic [11:0]   disp;
   logic          d0_first;   // high in the first cycle of state D0

   logic          tick;
   logic          boundary;
   logic [3:0]    nib;
   logic          suppress;
   logic [1:0]    nxt_dig;
   logic [6:0]    nxt_seg;

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;   // non-BCD nibble shows a dash
      endcase
      return s;
   endfunction

   assign tick       = (cnt == CNT_LAST);
   assign boundary   = tick && (state == S_GAP);
   assign load_ready = ~pend_full;

   // Next output values, computed from the current state so that dig_sel
   // and seg_out are registered together and never skew.
   always_comb begin
      nib      = 4'd0;
      suppress = 1'b0;
      nxt_dig  = 2'd3;
      nxt_seg  = SEG_OFF;
      case (state)
         S_D0: nib = disp[3:0];
         S_D1: begin
            nib      = disp[7:4];
            suppress = lzs_en && (disp[11:4] == 8'd0);
         end
         S_D2: begin
            nib      = disp[11:8];
            suppress = lzs_en && (disp[11:8] == 4'd0);
         end
         default: nib = 4'd0;
      endcase
      if (!blank_en && (state != S_GAP)) begin
         nxt_dig = state;
         nxt_seg = suppress ? SEG_OFF : seg_enc(nib);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_GAP;
         cnt         <= '0;
         pend        <= 12'd0;
         pend_full   <= 1'b0;
         disp        <= 12'd0;
         d0_first    <= 1'b0;
         dig_sel     <= DEC_WIDTH'(3);
         seg_out     <= SEG_OFF;
         frame_start <= 1'b0;
      end else begin
         cnt      <= tick ? '0 : cnt + CW'(1);
         d0_first <= 1'b0;

         if (tick) begin
            case (state)
               S_GAP: begin
                  state    <= S_D0;
                  d0_first <= 1'b1;
               end
               S_D0:    state <= S_D1;
               S_D1:    state <= S_D2;
               default: state <= S_GAP;
            endcase
         end

         // A load cannot coincide with the boundary copy: the copy needs
         // the buffer full, and loads need it empty.
         if (boundary && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
         end else if (load_valid && !pend_full) begin
            pend      <= bcd_in;
            pend_full <= 1'b1;
         end

         frame_start <= d0_first;
         dig_sel     <= DEC_WIDTH'(nxt_dig);
         seg_out     <= nxt_seg;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] bcd_in;
   logic        load_valid;
   logic        load_ready;
   logic        lzs_en;
   logic        blank_en;
   logic [1:0]  dig_sel;
   logic [6:0]  seg_out;
   logic        frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-written active-low segment table {g,f,e,d,c,b,a}.
   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
   };

   seg_scan_controller #(.CLK_DIV(4), .DEC_WIDTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bcd_in      (bcd_in),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .lzs_en      (lzs_en),
      .blank_en    (blank_en),
      .dig_sel     (dig_sel),
      .seg_out     (seg_out),
      .frame_start (frame_start)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int slot, input logic [11:0] d, input logic lzs);
      logic [3:0] n;
      if (slot == 3) return 7'b1111111;
      if (lzs && slot == 2 && d[11:8] == 4'd0) return 7'b1111111;
      if (lzs && slot == 1 && d[11:4] == 8'd0) return 7'b1111111;
      n = d[slot*4 +: 4];
      return seg_tab[n];
   endfunction

   // Checks one whole frame starting on its frame_start cycle; optionally
   // drives a load at frame-relative cycle load_at, and with hold keeps
   // load_valid high afterwards presenting hold_val.
   task automatic check_frame(input string tag, input logic [11:0] digits, input logic lzs,
                              input int load_at, input logic [11:0] load_val,
                              input logic hold, input logic [11:0] hold_val);
      int slot;
      for (int i = 0; i < 16; i++) begin
         slot = i / 4;
         check_eq({tag, "_fs"},  32'(frame_start), 32'(i == 0));
         check_eq({tag, "_dig"}, 32'(dig_sel), 32'(slot));
         check_eq({tag, "_seg"}, 32'(seg_out), 32'(exp_seg(slot, digits, lzs)));
         if (load_at >= 0 && i == load_at + 1)
            check_eq({tag, "_rdy_low"}, 32'(load_ready), 32'd0);
         if (hold && i == 15)
            check_eq({tag, "_rdy_back"}, 32'(load_ready), 32'd1);
         if (i == load_at) begin
            load_valid = 1'b1;
            bcd_in     = load_val;
         end else if (load_at >= 0 && i == load_at + 1) begin
            if (hold) bcd_in = hold_val;
            else      load_valid = 1'b0;
         end
         step();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic bl;
      int   slot;
      rst        = 1'b1;
      bcd_in     = 12'h000;
      load_valid = 1'b0;
      lzs_en     = 1'b0;
      blank_en   = 1'b0;
      step();
      step();
      rst = 1'b0;
      // cycle 0 after reset
      check_eq("rst_dig", 32'(dig_sel), 32'd3);
      check_eq("rst_seg", 32'(seg_out), 32'h7f);
      check_eq("rst_fs",  32'(frame_start), 32'd0);
      check_eq("rst_rdy", 32'(load_ready), 32'd1);
      step();                                  // cycle 1
      load_valid = 1'b1;
      bcd_in     = 12'h123;
      step();                                  // cycle 2
      load_valid = 1'b0;
      check_eq("rdy_c2", 32'(load_ready), 32'd0);
      step();                                  // cycle 3
      check_eq("rdy_c3", 32'(load_ready), 32'd0);
      check_eq("gap_dig_c3", 32'(dig_sel), 32'd3);
      step();                                  // cycle 4: boundary copy done
      check_eq("rdy_c4", 32'(load_ready), 32'd1);
      check_eq("fs_c4", 32'(frame_start), 32'd0);
      step();                                  // cycle 5: first frame

      check_frame("A_123", 12'h123, 1'b0, 2, 12'h005, 1'b0, 12'h000);
      lzs_en = 1'b1;
      check_frame("B_005_lzs", 12'h005, 1'b1, -1, 12'h000, 1'b0, 12'h000);
      lzs_en = 1'b0;
      check_frame("C_005_nolzs", 12'h005, 1'b0, 5, 12'h0A0, 1'b0, 12'h000);
      lzs_en = 1'b1;
      check_frame("D_0A0", 12'h0A0, 1'b1, -1, 12'h000, 1'b0, 12'h000);
      check_frame("E_0A0_load", 12'h0A0, 1'b1, 3, 12'h456, 1'b1, 12'h789);
      // 789 accepted in the cycle after the boundary copy
      check_eq("hold_rdy_low", 32'(load_ready), 32'd0);
      load_valid = 1'b0;
      check_frame("F_456", 12'h456, 1'b1, -1, 12'h000, 1'b0, 12'h000);
      check_frame("G_789", 12'h789, 1'b1, -1, 12'h000, 1'b0, 12'h000);

      // Blanking: pulse during D1, then blank from mid-D2 across the boundary.
      for (int i = 0; i < 17; i++) begin
         bl   = (i == 5) || (i >= 9);
         slot = (i % 16) / 4;
         check_eq("H_fs",  32'(frame_start), 32'(i % 16 == 0));
         check_eq("H_dig", 32'(dig_sel), (bl || slot == 3) ? 32'd3 : 32'(slot));
         check_eq("H_seg", 32'(seg_out), bl ? 32'h7f : 32'(exp_seg(slot, 12'h789, 1'b1)));
         blank_en = (i == 4) || (i >= 8 && i < 16);
         step();
      end
      check_eq("H_unblank_dig", 32'(dig_sel), 32'd0);
      check_eq("H_unblank_seg", 32'(seg_out), 32'b0010000);

      // Reset in the middle of D2 with the pending buffer full.
      load_valid = 1'b1;                       // frame I, i=1
      bcd_in     = 12'h123;
      step();                                  // i=2
      load_valid = 1'b0;
      check_eq("I_rdy_low", 32'(load_ready), 32'd0);
      for (int i = 2; i < 9; i++) step();      // i=9, output in D2
      check_eq("I_d2_dig", 32'(dig_sel), 32'd2);
      check_eq("I_d2_seg", 32'(seg_out), 32'b1111000);
      rst    = 1'b1;
      lzs_en = 1'b0;
      step();
      rst = 1'b0;
      check_eq("mid_rst_dig", 32'(dig_sel), 32'd3);
      check_eq("mid_rst_seg", 32'(seg_out), 32'h7f);
      check_eq("mid_rst_rdy", 32'(load_ready), 32'd1);
      check_eq("mid_rst_fs",  32'(frame_start), 32'd0);
      for (int i = 0; i < 5; i++) step();      // cycle 5 after reset
      check_frame("J_000", 12'h000, 1'b0, -1, 12'h000, 1'b0, 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Time-multiplexing scheduler for the 3-digit, common-anode 7-segment display driven by the binary-to-BCD converter. It accepts a 3-digit BCD word through a valid/ready handshake and double-buffers it so that updates apply only at frame boundaries. It cycles a 2-bit digit index through the three digits plus one all-off dead-time slot; that index drives the downstream digit-select decoder (index 0/1/2 = anode 0/1/2 active-low, index 3 = all anodes off). For the active digit it outputs the registered segment pattern, with leading-zero suppression and global blanking.

Parameters:
CLK_DIV, 50000, clocks per scan slot (dwell time per digit); legal range is 2 or more.
DEC_WIDTH, 2, width of the digit index fed to the decoder; fixed at 2.

Ports:
clk  input  1  system clock; one clock domain.
rst  input  1  synchronous, active-high reset.
bcd_in  input  12  {hundreds[11:8], tens[7:4], ones[3:0]} BCD word.
load_valid  input  1  bcd_in is valid this cycle.
load_ready  output  1  pending buffer is empty; a transfer occurs when load_valid and load_ready are both high.
lzs_en  input  1  leading-zero suppression enable.
blank_en  input  1  force the display dark.
dig_sel  output  DEC_WIDTH  digit index to the decoder (3 = all off).
seg_out  output  7  {g,f,e,d,c,b,a}, active-low.
frame_start  output  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset values: dig_sel=3; seg_out=7'b1111111; frame_start=0; load_ready=1; prescaler=0; display register=0; pending buffer empty.
- Prescaler: counts 0 to CLK_DIV-1. The tick occurs in the cycle where count equals CLK_DIV-1, and the count then wraps to 0.
- Slot state machine: GAP(3) -> D0(0, ones) -> D1(1, tens) -> D2(2, hundreds) -> GAP. The state advances only on a tick. After reset the block starts in GAP, so the first D0 begins CLK_DIV cycles after reset deasserts. Frame length is 4*CLK_DIV.
- Frame boundary is the tick in GAP. At that tick:
  - If the pending buffer is full, it is copied into the display register and the buffer is emptied.
  - frame_start is high in the first cycle of D0.
- Handshake: a transfer stores bcd_in into the pending buffer, and load_ready goes low the next cycle. load_ready returns high in the cycle after the boundary copy.
  - A transfer in the same cycle as a boundary copy is impossible, because load_ready is 0 whenever the buffer is full.
  - If the buffer is empty at a boundary, the display register is unchanged. A transfer in the boundary cycle is held in pending until the next frame.
  - load_valid with load_ready=0 is ignored; the data is not latched.
- Outputs are registered and update together, one cycle after the state change, so dig_sel and seg_out are never skewed.
- Segment encoding (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble values 10 to 15 display a dash, 0111111.
- Leading-zero suppression applies when lzs_en=1:
  - Hundreds slot is blank (1111111) if hundreds==0.
  - Tens slot is blank if hundreds==0 and tens==0.
  - Ones is never suppressed.
  - lzs_en is sampled every cycle.
- GAP slot: dig_sel=3 and seg_out=1111111, always.
- blank_en=1: from the next cycle, dig_sel=3 and seg_out=1111111. The prescaler, state machine, handshake and frame_start continue running unaffected. Deasserting blank_en resumes output for the current slot on the next cycle.
- Reset mid-operation: all state returns to the reset values in the cycle after rst is sampled high, and pending data is discarded.

Test Plan:
- Run with CLK_DIV=4. Reset, then load 12'h123 at cycle 1 -> load_ready low from cycle 2. At the cycle-4 boundary the word copies; load_ready returns high. From cycle 5: dig_sel 0,1,2,3 each for 4 cycles, with seg_out 0110000, 0100100, 1111001, 1111111. frame_start pulses at cycle 5 and every 16 cycles after.
- With lzs_en=1, load 12'h005 -> D2 and D1 blank (1111111), D0 shows 0010010. With lzs_en=0 -> D2 and D1 show 1000000.
- Load 12'h0A0 with lzs_en=1 -> tens shows dash 0111111; hundreds is blank.
- Load 12'h456 mid-frame, then hold load_valid high with 12'h789 -> the second word is not accepted until load_ready rises after the boundary. The display shows 456 for a full frame, then 789.
- Assert blank_en during D1 -> the next cycle shows dig_sel=3 and seg_out=1111111. Slot timing and frame_start period stay at 16 cycles. Deasserting blank_en restores the correct digit.
- Assert rst in the middle of D2 with pending full -> the next cycle shows dig_sel=3, seg_out=1111111, load_ready=1. The first frame after reset shows 000.
